// File: rtl/demod_frame_sync.sv
// demod_frame_sync
//   Frame synchroniser for the demodulator back end. Decided symbols are
//   serialised into a bit stream (I before Q in QPSK, I only in BPSK). The
//   block hunts for HEADER, checks a byte-sum checksum over the payload and
//   runs a hunt/verify/lock flywheel. Good frames are published on para_out.
//
// Ports
//   clk          sample clock, rising edge
//   rst_n        asynchronous active-low reset
//   sync_I       decided I bit, valid with sync_flag_i
//   sync_Q       decided Q bit, ignored in BPSK
//   sync_flag_i  one-cycle strobe at the optimum sampling instant
//   para_out     last good frame {header, data MSB-first, checksum}
//   valid_flag   pulse, para_out updated this cycle
//   header_flag  pulse, header matched
//   chk_err      pulse, frame body ended with a bad checksum
//   overrun_err  pulse, a strobe was dropped
//   locked       level, flywheel locked
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HUNT | sliding header search on every new bit
// ST_BODY | counting payload + checksum bits of the current frame
// ST_HDR  | counting the header field at the expected frame position

module demod_frame_sync #(
  parameter int unsigned HDR_W      = 8,
  parameter logic [HDR_W-1:0] HEADER = 8'hcc,
  parameter int unsigned DATA_BYTES = 3,
  parameter int unsigned MODE       = 1,
  parameter int unsigned LOCK_CNT   = 2,
  parameter int unsigned LOSS_CNT   = 3,
  localparam int unsigned FRAME_W   = HDR_W + 8*DATA_BYTES + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync_I,
  input  logic               sync_Q,
  input  logic               sync_flag_i,
  output logic [FRAME_W-1:0] para_out,
  output logic               valid_flag,
  output logic               header_flag,
  output logic               chk_err,
  output logic               overrun_err,
  output logic               locked
);

  localparam int unsigned BODY_W = 8*DATA_BYTES + 8;
  localparam int unsigned SR_W   = (BODY_W > HDR_W) ? BODY_W : HDR_W;
  localparam int unsigned CNT_W  = $clog2(SR_W + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 2);
  localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {ST_HUNT, ST_BODY, ST_HDR} state_t;

  state_t              state_q, state_d;
  logic [SR_W-2:0]     sr_q, sr_d;
  logic                q_pend_q, q_pend_d;
  logic                q_bit_q, q_bit_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                locked_q, locked_d;
  logic [FRAME_W-1:0]  para_q, para_d;
  logic                valid_q, valid_d;
  logic                hdr_q, hdr_d;
  logic                chk_q, chk_d;
  logic                ovr_q, ovr_d;

  logic                bit_v;
  logic                bit_in;
  logic [SR_W-1:0]     sr_next;
  logic [7:0]          byte_sum;
  logic                hdr_match;
  logic                miss_ev;

  // Serialiser. A pending Q bit always wins the cycle; a strobe colliding
  // with it is dropped entirely (its I and Q are both lost).
  always_comb begin
    bit_v    = 1'b0;
    bit_in   = 1'b0;
    q_pend_d = 1'b0;
    q_bit_d  = q_bit_q;
    ovr_d    = 1'b0;
    if (q_pend_q) begin
      bit_v  = 1'b1;
      bit_in = q_bit_q;
      ovr_d  = sync_flag_i;
    end else if (sync_flag_i) begin
      bit_v  = 1'b1;
      bit_in = sync_I;
      if (MODE != 0) begin
        q_pend_d = 1'b1;
        q_bit_d  = sync_Q;
      end
    end
  end

  // sr_next includes the bit arriving this cycle so field decisions are
  // made on the same cycle the last bit lands, and registered for output.
  assign sr_next   = {sr_q, bit_in};
  assign sr_d      = bit_v ? sr_next[SR_W-2:0] : sr_q;
  assign hdr_match = (sr_next[HDR_W-1:0] == HEADER);

  always_comb begin
    byte_sum = 8'h00;
    for (int b = 0; b < int'(DATA_BYTES); b++) begin
      byte_sum = byte_sum + sr_next[8 + 8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    locked_d   = locked_q;
    para_d     = para_q;
    valid_d    = 1'b0;
    hdr_d      = 1'b0;
    chk_d      = 1'b0;
    miss_ev    = 1'b0;

    case (state_q)
      ST_HUNT: begin
        good_cnt_d = '0;
        if (bit_v && hdr_match) begin
          hdr_d   = 1'b1;
          bcnt_d  = '0;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (bit_v) begin
          if (bcnt_q == CNT_W'(BODY_W - 1)) begin
            bcnt_d  = '0;
            state_d = ST_HDR;
            if (byte_sum == sr_next[7:0]) begin
              para_d     = {HEADER, sr_next[BODY_W-1:0]};
              valid_d    = 1'b1;
              miss_cnt_d = '0;
              if (good_cnt_q < GOOD_W'(LOCK_CNT)) begin
                good_cnt_d = good_cnt_q + GOOD_W'(1);
              end
              if (good_cnt_q + GOOD_W'(1) >= GOOD_W'(LOCK_CNT)) begin
                locked_d = 1'b1;
              end
            end else begin
              chk_d   = 1'b1;
              miss_ev = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
      end
      ST_HDR: begin
        if (bit_v) begin
          if (bcnt_q == CNT_W'(HDR_W - 1)) begin
            bcnt_d  = '0;
            state_d = ST_BODY;
            if (hdr_match) begin
              hdr_d = 1'b1;
            end else begin
              miss_ev = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        bcnt_d  = '0;
      end
    endcase

    // Flywheel: while locked, tolerate LOSS_CNT-1 consecutive misses on
    // frame timing; anything else drops back to a fresh hunt.
    if (miss_ev) begin
      if (locked_q && (int'(miss_cnt_q) + 1 < int'(LOSS_CNT))) begin
        miss_cnt_d = miss_cnt_q + MISS_W'(1);
      end else begin
        locked_d   = 1'b0;
        miss_cnt_d = '0;
        good_cnt_d = '0;
        bcnt_d     = '0;
        state_d    = ST_HUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      sr_q       <= '0;
      q_pend_q   <= 1'b0;
      q_bit_q    <= 1'b0;
      bcnt_q     <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      locked_q   <= 1'b0;
      para_q     <= '0;
      valid_q    <= 1'b0;
      hdr_q      <= 1'b0;
      chk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      q_pend_q   <= q_pend_d;
      q_bit_q    <= q_bit_d;
      bcnt_q     <= bcnt_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      locked_q   <= locked_d;
      para_q     <= para_d;
      valid_q    <= valid_d;
      hdr_q      <= hdr_d;
      chk_q      <= chk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign para_out    = para_q;
  assign valid_flag  = valid_q;
  assign header_flag = hdr_q;
  assign chk_err     = chk_q;
  assign overrun_err = ovr_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_demod_frame_sync.sv
// Directed bench for demod_frame_sync: one QPSK instance walking through
// acquisition, lock, flywheel, loss, reset and overrun, plus one BPSK
// instance for the misaligned sliding hunt.

module tb_demod_frame_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_I = 1'b0, sync_Q = 1'b0, sync_flag_i = 1'b0;
  logic [39:0] para_out;
  logic        valid_flag, header_flag, chk_err, overrun_err, locked;

  logic        ib = 1'b0, fb = 1'b0;
  logic [39:0] para_b;
  logic        valid_b, hdr_b, chk_b, ovr_b, locked_b;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_hdr = 0, n_chk = 0, n_ovr = 0, n_valid_b = 0;
  logic lock_at_valid = 1'b0;

  localparam logic [39:0] F_GOOD = 40'hcc1234569c;
  localparam logic [39:0] F_BAD  = 40'hcc1234569d;
  localparam logic [39:0] F_NOHD = 40'h001234569d;
  localparam logic [39:0] F_SMALL = 40'hcc01020306;

  always #5 clk = ~clk;

  demod_frame_sync #(.MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .sync_I(sync_I), .sync_Q(sync_Q),
    .sync_flag_i(sync_flag_i), .para_out(para_out), .valid_flag(valid_flag),
    .header_flag(header_flag), .chk_err(chk_err), .overrun_err(overrun_err),
    .locked(locked)
  );

  demod_frame_sync #(.MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .sync_I(ib), .sync_Q(1'b0),
    .sync_flag_i(fb), .para_out(para_b), .valid_flag(valid_b),
    .header_flag(hdr_b), .chk_err(chk_b), .overrun_err(ovr_b),
    .locked(locked_b)
  );

  always @(negedge clk) begin
    if (valid_flag) begin
      n_valid <= n_valid + 1;
      lock_at_valid <= locked;
    end
    if (header_flag) n_hdr <= n_hdr + 1;
    if (chk_err)     n_chk <= n_chk + 1;
    if (overrun_err) n_ovr <= n_ovr + 1;
    if (valid_b)     n_valid_b <= n_valid_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One QPSK symbol, then idle so strobes are 5 cycles apart.
  task automatic send_sym(input logic i, input logic q);
    @(posedge clk); #1;
    sync_flag_i = 1'b1; sync_I = i; sync_Q = q;
    @(posedge clk); #1;
    sync_flag_i = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_syms(input logic [39:0] f, input int first, input int last);
    for (int k = first; k <= last; k++) send_sym(f[39-2*k], f[38-2*k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rnd;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_para", para_out, 40'h0);
    check("reset_pulses", {valid_flag, header_flag, chk_err, overrun_err, locked}, 5'b0);

    // QPSK single frame; header completes on strobe 4's Q bit
    send_syms(F_GOOD, 0, 2);
    check("hdr_early", n_hdr, 0);
    send_syms(F_GOOD, 3, 3);
    check("hdr_after_s4", n_hdr, 1);
    send_syms(F_GOOD, 4, 19);
    check("f1_valid", n_valid, 1);
    check("f1_para", para_out, F_GOOD);
    check("f1_unlocked", locked, 0);

    // Second good frame locks
    send_syms(F_GOOD, 0, 19);
    check("f2_valid", n_valid, 2);
    check("f2_lock_with_valid", lock_at_valid, 1);
    check("f2_hdr", n_hdr, 2);

    // Bad checksum while locked: flywheel holds
    send_syms(F_BAD, 0, 19);
    check("f3_chk", n_chk, 1);
    check("f3_no_valid", n_valid, 2);
    check("f3_para_held", para_out, F_GOOD);
    check("f3_locked", locked, 1);
    check("f3_miss", dut.miss_cnt_q, 1);

    send_syms(F_GOOD, 0, 19);
    check("f4_valid", n_valid, 3);
    check("f4_miss_clr", dut.miss_cnt_q, 0);

    // Loss: missing header (miss 1), bad body (miss 2), missing header (loss)
    send_syms(F_NOHD, 0, 19);
    check("la_chk", n_chk, 2);
    check("la_locked", locked, 1);
    send_syms(F_NOHD, 0, 3);
    check("lb_unlocked", locked, 0);
    send_syms(F_NOHD, 4, 19);
    check("loss_no_hdr", n_hdr, 4);
    check("loss_no_chk", n_chk, 2);

    send_syms(F_GOOD, 0, 19);
    check("reacq_valid", n_valid, 4);
    check("reacq_unlocked", locked, 0);
    send_syms(F_GOOD, 0, 19);
    check("reacq_locked", locked, 1);

    // Reset halfway through a body
    send_syms(F_SMALL, 0, 11);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_para", para_out, 40'h0);
    check("rst_outs", {valid_flag, header_flag, chk_err, overrun_err, locked}, 5'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_syms(F_SMALL, 0, 19);
    check("rst_valid", n_valid, 6);
    check("rst_para_new", para_out, F_SMALL);
    check("rst_fresh_unlocked", locked, 0);

    // Overrun: strobes in adjacent cycles
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("ovr_none_yet", n_ovr, 0);
    @(posedge clk); #1 sync_flag_i = 1'b1; sync_I = 1'b1; sync_Q = 1'b0;
    @(posedge clk); #1 sync_flag_i = 1'b1; sync_I = 1'b1; sync_Q = 1'b1;
    @(posedge clk); #1 sync_flag_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ovr_count", n_ovr, 1);
    check("ovr_sr", dut.sr_q, 2);

    // BPSK: 3 random bits then the frame, one strobe per cycle
    rnd = 3'($urandom_range(0, 7));
    for (int k = 0; k < 43; k++) begin
      @(posedge clk); #1;
      fb = 1'b1;
      ib = (k < 3) ? rnd[2-k] : F_SMALL[42-k];
    end
    @(negedge clk);
    check("bpsk_not_early", {28'h0, valid_b, n_valid_b[3:0]}, 0);
    @(posedge clk); #1 fb = 1'b0;
    @(negedge clk);
    check("bpsk_valid", valid_b, 1);
    check("bpsk_para", para_b, F_SMALL);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bpsk_once", n_valid_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
